// File: rtl/barker_frame_serializer.sv
// Barker frame serializer: takes a parallel FRAME_LEN-bit word on a valid/ready input and
// emits it MSB first as a serial valid/ready/last stream. A one-word holding register in front
// of the shift register lets frames run back to back with no idle bit between them.
module barker_frame_serializer #(
   parameter int unsigned FRAME_LEN = 11,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [FRAME_LEN-1:0] s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic                 m_tdata,
   output logic                 m_tvalid,
   output logic                 m_tlast,
   input  logic                 m_tready,
   output logic [CNT_W-1:0]     o_frame_cnt,
   output logic                 o_busy
);

   localparam int unsigned     IdxW    = $clog2(FRAME_LEN);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

   // StSend means the shift register holds a valid frame.
   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e               state_q, state_d;
   logic [FRAME_LEN-1:0] hold_data_q, hold_data_d;
   logic [FRAME_LEN-1:0] shift_data_q, shift_data_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 s_tready_q, s_tready_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;

   logic in_accept;
   logic bit_accept;
   logic last_accept;
   logic load;

   // Handshake decode shared by the FSM and the datapath.
   always_comb begin
      in_accept   = s_tvalid & s_tready_q;
      bit_accept  = (state_q == StSend) & m_tready;
      last_accept = bit_accept & (idx_q == LastIdx);
      // Refill the shifter when it is empty or is releasing its final bit this cycle.
      load        = hold_valid_q & ((state_q == StIdle) | last_accept);
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StSend;
            end
         end
         StSend: begin
            // With HOLD full the next frame loads in the same cycle, so stay in StSend.
            if (last_accept && !hold_valid_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and status outputs.
   always_comb begin
      m_tvalid    = (state_q == StSend);
      m_tlast     = (state_q == StSend) && (idx_q == LastIdx);
      m_tdata     = (state_q == StSend) && shift_data_q[FRAME_LEN-1];
      s_tready    = s_tready_q;
      o_busy      = hold_valid_q | (state_q == StSend);
      o_frame_cnt = frame_cnt_q;
   end

   // Datapath next-state: holding register, shifter, bit index and frame counter.
   always_comb begin
      hold_data_d  = hold_data_q;
      shift_data_d = shift_data_q;
      idx_d        = idx_q;
      frame_cnt_d  = frame_cnt_q;

      if (in_accept) begin
         hold_data_d = s_tdata;
      end
      // A write and a transfer in the same cycle leave HOLD full with the new word.
      hold_valid_d = (hold_valid_q & ~load) | in_accept;
      // Registered ready: depends only on next HOLD occupancy, never on m_tready directly.
      s_tready_d   = ~hold_valid_d;

      if (load) begin
         shift_data_d = hold_data_q;
         idx_d        = '0;
      end else if (last_accept) begin
         idx_d = '0;
      end else if (bit_accept) begin
         // Shift left so the bit on the wire is always the MSB.
         shift_data_d = shift_data_q << 1;
         idx_d        = idx_q + IdxW'(1);
      end

      if (last_accept) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold_data_q  <= '0;
         shift_data_q <= '0;
         hold_valid_q <= 1'b0;
         s_tready_q   <= 1'b0;
         idx_q        <= '0;
         frame_cnt_q  <= '0;
      end else begin
         hold_data_q  <= hold_data_d;
         shift_data_q <= shift_data_d;
         hold_valid_q <= hold_valid_d;
         s_tready_q   <= s_tready_d;
         idx_q        <= idx_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_barker_frame_serializer.sv
// Directed bench for barker_frame_serializer: reset, single frame, back-to-back, backpressure,
// reset mid-frame, counter wrap (second instance with a 2-bit counter) and a Barker loopback.
module tb_barker_frame_serializer;

   localparam logic [10:0] Barker = 11'b11100010010;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] s_tdata;
   logic        s_tvalid;
   logic        m_tready;

   logic        s_tready, m_tdata, m_tvalid, m_tlast, o_busy;
   logic [15:0] cnt;
   logic        s_tready2, m_tdata2, m_tvalid2, m_tlast2, o_busy2;
   logic [1:0]  cnt2;

   int tests = 0;
   int fails = 0;

   logic        bits[$];
   logic        lasts[$];
   logic        acc_evt;
   logic [10:0] win;
   int          det;

   always #5 clk = ~clk;

   barker_frame_serializer #(.FRAME_LEN(11), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .o_frame_cnt(cnt), .o_busy(o_busy)
   );

   barker_frame_serializer #(.FRAME_LEN(11), .CNT_W(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready2),
      .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tready(m_tready),
      .o_frame_cnt(cnt2), .o_busy(o_busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: record handshakes before the edge, check stall stability after it.
   task automatic tick();
      logic stall, pd, pl;
      stall   = m_tvalid && !m_tready && !rst;
      pd      = m_tdata;
      pl      = m_tlast;
      acc_evt = s_tvalid && s_tready && !rst;
      if (m_tvalid && m_tready && !rst) begin
         bits.push_back(m_tdata);
         lasts.push_back(m_tlast);
         win = {win[9:0], m_tdata};
         if (win == Barker) det++;
      end
      @(posedge clk);
      #1;
      if (stall && !rst) begin
         chk("stall_valid", 32'(m_tvalid), 32'd1);
         chk("stall_data", 32'(m_tdata), 32'(pd));
         chk("stall_last", 32'(m_tlast), 32'(pl));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send_frame(input logic [10:0] d);
      logic got;
      got      = 1'b0;
      s_tdata  = d;
      s_tvalid = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         tick();
         got = acc_evt;
      end
      chk("accept", 32'(got), 32'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic collect(input int n);
      for (int k = 0; k < 500 && bits.size() < n; k++) tick();
      chk("nbits", 32'(bits.size()), 32'(n));
   endtask

   task automatic chk_frame(input string tag, input int base, input logic [10:0] w);
      for (int i = 0; i < 11; i++) begin
         if (base + i < bits.size()) begin
            chk(tag, 32'(bits[base+i]), 32'(w[10-i]));
            chk("tlast", 32'(lasts[base+i]), 32'(i == 10));
         end
      end
   endtask

   initial begin
      logic [10:0] fr[3];
      logic [10:0] w;
      int          nf, gaps;
      int          wrap_seq[5];

      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      win      = '0;
      det      = 0;

      // Reset state
      tick();
      tick();
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk("tready_after_rst", 32'(s_tready), 32'd1);

      // Single frame with latency check
      m_tready = 1'b1;
      bits.delete();
      lasts.delete();
      s_tdata  = Barker;
      s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
      chk("lat1_tvalid", 32'(m_tvalid), 32'd0);
      chk("lat1_busy", 32'(o_busy), 32'd1);
      chk("lat1_tready", 32'(s_tready), 32'd0);
      tick();
      chk("lat2_tvalid", 32'(m_tvalid), 32'd1);
      chk("lat2_tready", 32'(s_tready), 32'd1);
      collect(11);
      chk_frame("single_bit", 0, Barker);
      chk("single_cnt", 32'(cnt), 32'd1);
      chk("single_busy", 32'(o_busy), 32'd0);
      chk("single_tvalid", 32'(m_tvalid), 32'd0);

      // Back-to-back: three frames, no gaps
      fr[0] = Barker;
      fr[1] = 11'b01011010011;
      fr[2] = 11'b10000111101;
      bits.delete();
      lasts.delete();
      nf       = 0;
      gaps     = 0;
      s_tdata  = fr[0];
      s_tvalid = 1'b1;
      for (int k = 0; k < 300 && bits.size() < 33; k++) begin
         if (bits.size() > 0 && !m_tvalid) gaps++;
         tick();
         if (acc_evt) begin
            nf++;
            if (nf < 3) s_tdata = fr[nf];
            else s_tvalid = 1'b0;
         end
      end
      chk("b2b_nbits", 32'(bits.size()), 32'd33);
      chk("b2b_gaps", 32'(gaps), 32'd0);
      for (int f = 0; f < 3; f++) chk_frame("b2b_bit", 11 * f, fr[f]);
      chk("b2b_cnt", 32'(cnt), 32'd4);
      chk("b2b_cnt2", 32'(cnt2), 32'd0);

      // Backpressure: random m_tready, two frames
      fr[0] = 11'b10110011101;
      fr[1] = 11'b00101100110;
      bits.delete();
      lasts.delete();
      nf       = 0;
      s_tdata  = fr[0];
      s_tvalid = 1'b1;
      for (int k = 0; k < 400 && bits.size() < 22; k++) begin
         m_tready = 1'($urandom_range(0, 1));
         tick();
         if (acc_evt) begin
            chk("bp_hold_full_tready", 32'(s_tready), 32'd0);
            nf++;
            if (nf < 2) s_tdata = fr[nf];
            else s_tvalid = 1'b0;
         end
      end
      m_tready = 1'b1;
      chk("bp_nbits", 32'(bits.size()), 32'd22);
      for (int f = 0; f < 2; f++) chk_frame("bp_bit", 11 * f, fr[f]);
      chk("bp_cnt", 32'(cnt), 32'd6);

      // Reset mid-frame after five bits
      bits.delete();
      lasts.delete();
      send_frame(11'b10110011101);
      collect(5);
      rst = 1'b1;
      tick();
      chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
      chk("midrst_busy", 32'(o_busy), 32'd0);
      chk("midrst_cnt", 32'(cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk("midrst_tready", 32'(s_tready), 32'd1);
      chk("midrst_idle", 32'(m_tvalid), 32'd0);
      bits.delete();
      lasts.delete();
      w = 11'b01100101011;
      send_frame(w);
      collect(11);
      chk_frame("midrst_bit", 0, w);
      chk("midrst_cnt_after", 32'(cnt), 32'd1);

      // Counter wrap on the 2-bit instance
      do_reset();
      wrap_seq = '{1, 2, 3, 0, 1};
      bits.delete();
      lasts.delete();
      for (int f = 0; f < 5; f++) begin
         send_frame(11'b11001010001);
         collect(11 * (f + 1));
         chk("wrap_cnt2", 32'(cnt2), 32'(wrap_seq[f]));
         chk("wrap_cnt", 32'(cnt), 32'(f + 1));
      end

      // Loopback through a sliding-window Barker correlator
      do_reset();
      win = '0;
      det = 0;
      bits.delete();
      lasts.delete();
      send_frame(Barker);
      collect(11);
      chk("loop_det_first", 32'(det), 32'd1);
      send_frame(11'b00000000000);
      collect(22);
      chk("loop_det_total", 32'(det), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
